// File: rtl/usbdev_pkg.sv
// Shared types for the usbdev AON wake sequencer: FSM state encoding and the
// latched wake-reason layout.
package usbdev_pkg;

  typedef enum logic [2:0] {
    AWK_IDLE   = 3'd0,
    AWK_REQ    = 3'd1,
    AWK_ARMED  = 3'd2,
    AWK_WAKE   = 3'd3,
    AWK_ACK    = 3'd4,
    AWK_SETTLE = 3'd5
  } awk_seq_state_e;

  typedef struct packed {
    logic sense_lost;
    logic bus_reset;
    logic bus_not_idle;
  } awk_reason_t;

  // True for states in which the shared timer runs.
  function automatic logic awk_timed_state(awk_seq_state_e s);
    return (s == AWK_REQ) || (s == AWK_ACK) || (s == AWK_SETTLE);
  endfunction

endpackage

// File: rtl/usbdev_aon_wake_timer.sv
// Saturating cycle counter with synchronous clear; done flags the cycle in
// which the count reaches the limit, so a state lasts exactly `limit` cycles.
module usbdev_aon_wake_timer #(
  parameter int unsigned CntW = 6
) (
  input  logic            clk_aon_i,
  input  logic            rst_aon_i,
  input  logic            clear,
  input  logic            enable,
  input  logic [CntW-1:0] limit,
  output logic            done
);

  logic [CntW-1:0] cnt_q;
  logic [CntW:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};
  assign done    = enable && (cnt_inc >= {1'b0, limit});

  always_ff @(posedge clk_aon_i or posedge rst_aon_i) begin
    if (rst_aon_i) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q < limit)) begin
      cnt_q <= cnt_inc[CntW-1:0];
    end
  end

endmodule

// File: rtl/usbdev_aon_wake_seq.sv
// AON-domain sequencer driving the wake detector suspend_req/wake_ack handshake,
// latching wake reasons and raising a level interrupt to software.
module usbdev_aon_wake_seq
  import usbdev_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 32,
  parameter int unsigned SettleCycles  = 4
) (
  input  logic       clk_aon_i,
  input  logic       rst_aon_i,
  input  logic       sw_suspend_aon_i,
  input  logic       sw_wake_ack_aon_i,
  input  logic       det_active_i,
  input  logic       det_wake_req_i,
  input  logic       det_bus_not_idle_i,
  input  logic       det_bus_reset_i,
  input  logic       det_sense_lost_i,
  output logic       suspend_req_o,
  output logic       wake_ack_o,
  output logic       wake_irq_o,
  output logic [2:0] wake_reason_o,
  output logic       timeout_err_o,
  output logic [2:0] state_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  awk_seq_state_e  state_q, state_d;
  awk_reason_t     reason_q, reason_d, det_evt;
  logic            err_q, err_d;
  logic            sw_prev_q, sw_rise;
  logic            t_clear, t_en, t_done;
  logic [CntW-1:0] t_limit;

  assign det_evt = {det_sense_lost_i, det_bus_reset_i, det_bus_not_idle_i};
  assign sw_rise = sw_suspend_aon_i && !sw_prev_q;

  assign t_en    = awk_timed_state(state_q);
  assign t_limit = (state_q == AWK_SETTLE) ? CntW'(SettleCycles) : CntW'(TimeoutCycles);
  assign t_clear = (state_d != state_q);

  usbdev_aon_wake_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk_aon_i (clk_aon_i),
    .rst_aon_i (rst_aon_i),
    .clear     (t_clear),
    .enable    (t_en),
    .limit     (t_limit),
    .done      (t_done)
  );

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    err_d    = err_q;
    unique case (state_q)
      AWK_IDLE: begin
        if (sw_rise) begin
          state_d  = AWK_REQ;
          reason_d = '0;
        end
      end
      AWK_REQ: begin
        if (det_active_i) begin
          state_d = AWK_ARMED;
        end else if (t_done) begin
          state_d = AWK_IDLE;
          err_d   = 1'b1;
        end
      end
      AWK_ARMED: begin
        // A wake request wins over a same-cycle software ack; the ack is dropped.
        if (det_wake_req_i) begin
          state_d  = AWK_WAKE;
          reason_d = awk_reason_t'(reason_q | det_evt);
        end else if (sw_wake_ack_aon_i) begin
          state_d = AWK_ACK;
        end else if (!det_active_i) begin
          state_d = AWK_IDLE;
        end
      end
      AWK_WAKE: begin
        reason_d = awk_reason_t'(reason_q | det_evt);
        if (sw_wake_ack_aon_i) begin
          state_d = AWK_ACK;
        end
      end
      AWK_ACK: begin
        if (!det_active_i) begin
          state_d = AWK_SETTLE;
        end else if (t_done) begin
          state_d = AWK_IDLE;
          err_d   = 1'b1;
        end
      end
      AWK_SETTLE: begin
        if (t_done) begin
          state_d = AWK_IDLE;
        end
      end
      default: state_d = AWK_IDLE;
    endcase
  end

  // sw_prev resets high so a suspend level already present at reset release
  // is not mistaken for a fresh request.
  always_ff @(posedge clk_aon_i or posedge rst_aon_i) begin
    if (rst_aon_i) begin
      state_q   <= AWK_IDLE;
      reason_q  <= '0;
      err_q     <= 1'b0;
      sw_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      reason_q  <= reason_d;
      err_q     <= err_d;
      sw_prev_q <= sw_suspend_aon_i;
    end
  end

  always_ff @(posedge clk_aon_i or posedge rst_aon_i) begin
    if (rst_aon_i) begin
      suspend_req_o <= 1'b0;
      wake_ack_o    <= 1'b0;
      wake_irq_o    <= 1'b0;
      wake_reason_o <= 3'b000;
      timeout_err_o <= 1'b0;
      state_o       <= 3'b000;
    end else begin
      suspend_req_o <= (state_q == AWK_REQ);
      wake_ack_o    <= (state_q == AWK_ACK);
      wake_irq_o    <= (state_q == AWK_WAKE);
      wake_reason_o <= reason_q;
      timeout_err_o <= err_q;
      state_o       <= state_q;
    end
  end

  assert_known_outputs: assert property (@(posedge clk_aon_i) disable iff (rst_aon_i)
    !$isunknown({suspend_req_o, wake_ack_o, wake_irq_o, wake_reason_o, timeout_err_o, state_o}));

  assert_req_ack_exclusive: assert property (@(posedge clk_aon_i) disable iff (rst_aon_i)
    !(suspend_req_o && wake_ack_o));

endmodule
